mux21_4_arb: RTL and testbench

// Round-robin arbiter that shares one 4-bit 2:1 mux datapath (mux21_4) between two requesters.

---
 rtl/mux21_4_arb.sv | 119 +++++++++++
 tb/tb_mux21_4_arb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux21_4_arb.sv
// ============================================================================
// Module      : mux21_4_arb
// Description : Round-robin arbiter sharing a registered 4-bit 2:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux21_4_arb #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] dat0,
    input  logic [3:0] dat1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic [3:0] out_dat,
    output logic       out_vld
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] C_HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            last_q, last_d;
    logic [3:0]      out_dat_q, out_dat_d;
    logic            out_vld_q, out_vld_d;

    logic            own_req;
    logic            oth_req;
    logic [3:0]      own_dat;
    logic            own_id;
    state_t          oth_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            out_dat_q  <= 4'h0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
        end
    end

    always_comb begin
        own_id     = (state_q == OWN1);
        own_req    = own_id ? req1 : req0;
        oth_req    = own_id ? req0 : req1;
        own_dat    = own_id ? dat1 : dat0;
        oth_state  = own_id ? OWN0 : OWN1;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                // last names the previous owner, so a tie goes to the other side
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    last_d     = own_id;
                    hold_cnt_d = '0;
                    state_d    = oth_req ? oth_state : IDLE;
                end else begin
                    out_vld_d = 1'b1;
                    out_dat_d = own_dat;
                    if (oth_req && (hold_cnt_q == C_HOLD_MAX)) begin
                        last_d     = own_id;
                        hold_cnt_d = '0;
                        state_d    = oth_state;
                    end else if (hold_cnt_q != C_HOLD_MAX) begin
                        // saturate while uncontested so a late rival gets the very next slot
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign sel     = (state_q == OWN1);
    assign out_dat = out_dat_q;
    assign out_vld = out_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_mux21_4_arb.sv
// ============================================================================
// Module      : tb_mux21_4_arb
// Description : Directed vector table plus multi-cycle sequences for mux21_4_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux21_4_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] dat0, dat1;
    logic       gnt0, gnt1, sel, out_vld;
    logic [3:0] out_dat;

    int errors = 0;
    int checks = 0;

    mux21_4_arb #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .dat0    (dat0),
        .dat1    (dat1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .out_dat (out_dat),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [7:0] pk(input logic g0, input logic g1, input logic s,
                                      input logic v, input logic [3:0] d);
        return {g0, g1, s, v, d};
    endfunction

    function automatic logic [7:0] obs();
        return {gnt0, gnt1, sel, out_vld, out_dat};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {g0,g1,sel,vld,dat}=%b_%h required %b_%h",
                     name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic r, input logic r0, input logic r1,
                         input logic [3:0] d0, input logic [3:0] d1);
        rst = r; req0 = r0; req1 = r1; dat0 = d0; dat1 = d1;
    endtask

    initial begin
        // Expected fields: gnt0, gnt1, sel, out_vld, out_dat (after the edge)
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, pk(0, 0, 0, 0, 4'h0)};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, pk(0, 0, 0, 0, 4'h0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'hA, 4'h0, pk(1, 0, 0, 0, 4'h0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'hA, 4'h0, pk(1, 0, 0, 1, 4'hA)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'hA, 4'h0, pk(1, 0, 0, 1, 4'hA)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'hA, 4'h0, pk(1, 0, 0, 1, 4'hA)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h0, pk(0, 0, 0, 0, 4'hA)};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h3, 4'h0, pk(1, 0, 0, 0, 4'hA)};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h5, pk(1, 0, 0, 1, 4'h3)};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'h4, 4'h5, pk(1, 0, 0, 1, 4'h4)};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'h4, 4'h5, pk(0, 1, 1, 0, 4'h4)};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'h4, 4'h5, pk(0, 1, 1, 1, 4'h5)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h4, 4'h5, pk(0, 0, 0, 0, 4'h5)};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 4'h6, 4'h7, pk(1, 0, 0, 0, 4'h5)};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'h6, 4'h7, pk(0, 1, 1, 0, 4'h5)};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h6, 4'h7, pk(0, 0, 0, 0, 4'h5)};

        drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Saturation: uncontested owner runs past MAX_HOLD, then a late rival arrives
        drive(1'b0, 1'b1, 1'b0, 4'h9, 4'h2);
        @(posedge clk); #1;
        check("sat_grant", obs(), pk(1, 0, 0, 0, 4'h5));
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat_xfer%0d", k), obs(), pk(1, 0, 0, 1, 4'h9));
        end
        req1 = 1'b1;
        @(posedge clk); #1;
        check("sat_handoff", obs(), pk(0, 1, 1, 1, 4'h9));
        @(posedge clk); #1;
        check("sat_own1_xfer", obs(), pk(0, 1, 1, 1, 4'h2));
        drive(1'b0, 1'b0, 1'b0, 4'h9, 4'h2);
        @(posedge clk); #1;
        check("sat_idle", obs(), pk(0, 0, 0, 0, 4'h2));

        // Fresh tie from reset, both held: alternating 8-transfer bursts, no gap
        rst = 1'b1;
        #1;
        check("fair_rst", obs(), pk(0, 0, 0, 0, 4'h0));
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 4'hA, 4'h5);
        for (int k = 1; k <= 44; k++) begin
            logic [7:0] e;
            int t, ot, on;
            @(posedge clk); #1;
            if (k == 1) begin
                e = pk(1, 0, 0, 0, 4'h0);
            end else begin
                t  = k - 2;
                ot = (t / 8) % 2;
                on = ((t + 1) / 8) % 2;
                e  = pk(on == 0, on == 1, on == 1, 1'b1, (ot == 1) ? 4'h5 : 4'hA);
            end
            check($sformatf("fair_k%0d", k), obs(), e);
        end

        // Asynchronous reset mid-burst while OWN1 holds the datapath
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", obs(), pk(0, 0, 0, 0, 4'h0));
        @(posedge clk); #1;
        check("async_rst_held", obs(), pk(0, 0, 0, 0, 4'h0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_tie", obs(), pk(1, 0, 0, 0, 4'h0));
        @(posedge clk); #1;
        check("post_rst_xfer", obs(), pk(1, 0, 0, 1, 4'hA));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    always @(negedge clk) begin
        if (gnt0 && gnt1) begin
            errors++;
            checks++;
            $display("FAIL dual_grant: got gnt0=%b gnt1=%b required not both 1", gnt0, gnt1);
        end
    end

endmodule

`default_nettype wire
